// File: rtl/hni_rx_lcrd_chan_pkg.sv
// Shared constants and types for the HNI RX link-layer channel receiver.
//   - Opcode field location and per-channel LCrdReturn opcodes
//   - Default credit pool and buffer depth per channel
//   - Per-cycle event bundle used by the credit accounting
package hni_rx_lcrd_chan_pkg;

    // Opcode field position inside a flit
    localparam int unsigned HNI_OPC_LSB   = 12;
    localparam int unsigned HNI_OPC_WIDTH = 4;

    // LCrdReturn opcode per RX channel
    localparam int unsigned HNI_REQ_LCRDRET_OPC = 0;
    localparam int unsigned HNI_RSP_LCRDRET_OPC = 0;
    localparam int unsigned HNI_DAT_LCRDRET_OPC = 0;

    // Default credit pool and buffer depth per RX channel
    localparam int unsigned HNI_REQ_LCRD_NUM  = 4;
    localparam int unsigned HNI_REQ_BUF_DEPTH = 4;
    localparam int unsigned HNI_RSP_LCRD_NUM  = 4;
    localparam int unsigned HNI_RSP_BUF_DEPTH = 4;
    localparam int unsigned HNI_DAT_LCRD_NUM  = 4;
    localparam int unsigned HNI_DAT_BUF_DEPTH = 4;

    // Bits needed to hold the values 0..n inclusive
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Everything that can move a credit in one cycle
    typedef struct packed {
        logic issue;    // grant a credit to the transmitter
        logic lcrdret;  // LCrdReturn absorbed, credit back to the pool
        logic push;     // data flit accepted into the buffer
        logic pop;      // consumer drained the head flit
        logic err;      // flit dropped (no credit outstanding or buffer full)
    } rx_evt_t;

endpackage

// File: rtl/hni_rx_lcrd_chan_sync_fifo.sv
// hni_sync_fifo: single-clock FIFO with wrap-around pointers, reused by HNI queues.
//   push/wdata : write side, ignored when full
//   pop/rdata  : read side, rdata is the head entry, pop ignored when empty
//   full/empty/count : occupancy, all derived from registered state
module hni_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : AW'(p + AW'(1));
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rd_ptr_q];

    // Next-state pointers and occupancy
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        count_d = CW'(count_q + CW'(do_push) - CW'(do_pop));
    end

    // Control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; validity comes from count_q alone
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/hni_rx_lcrd_chan.sv
// hni_rx_lcrd_chan: CHI RX link-layer channel receiver with L-credit pool.
//   clk, rst_n        : clock, async active-low reset
//   rx_enable         : 1 = issue credits, 0 = deactivate
//   rxflitpend        : early flit hint, only feeds rx_active
//   rxflitv, rxflit   : incoming flit
//   rxlcrdv           : registered credit grant
//   out_valid/out_flit/out_ready : buffered flit towards the HNI queue
//   rx_active         : clock-gating hint
//   idle              : no credits outstanding, buffer empty, link disabled
//   prot_err          : sticky protocol error (flit without credit / overflow)
module hni_rx_lcrd_chan
    import hni_rx_lcrd_chan_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH  = 392,
    parameter int unsigned LCRD_NUM    = HNI_DAT_LCRD_NUM,
    parameter int unsigned BUF_DEPTH   = HNI_DAT_BUF_DEPTH,
    parameter int unsigned OPC_LSB     = HNI_OPC_LSB,
    parameter int unsigned OPC_WIDTH   = HNI_OPC_WIDTH,
    parameter int unsigned LCRDRET_OPC = HNI_DAT_LCRDRET_OPC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_enable,
    input  logic                  rxflitpend,
    input  logic                  rxflitv,
    input  logic [FLIT_WIDTH-1:0] rxflit,
    output logic                  rxlcrdv,
    output logic                  out_valid,
    output logic [FLIT_WIDTH-1:0] out_flit,
    input  logic                  out_ready,
    output logic                  rx_active,
    output logic                  idle,
    output logic                  prot_err
);

    localparam int unsigned CW  = cnt_width(LCRD_NUM);
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned FCW = $clog2(BUF_DEPTH + 1);

    logic [CW-1:0]         avail_q, avail_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic                  rxlcrdv_q, rxlcrdv_d;
    logic                  prot_err_q, prot_err_d;
    logic                  idle_q, idle_d;
    logic                  rxflitpend_q, rxflitpend_d;

    rx_evt_t               evt;
    logic [OPC_WIDTH-1:0]  opc;
    logic                  has_outst;
    logic                  is_ret;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FCW-1:0]        fifo_count;
    logic [FLIT_WIDTH-1:0] fifo_rdata;

    assign opc = rxflit[OPC_LSB +: OPC_WIDTH];

    // Credit accounting: every event is resolved in one cycle and netted
    always_comb begin
        evt       = '0;
        has_outst = (outst_q != '0);
        is_ret    = (opc == OPC_WIDTH'(LCRDRET_OPC));

        evt.lcrdret = rxflitv & has_outst & is_ret;
        evt.push    = rxflitv & has_outst & ~is_ret & ~fifo_full;
        evt.err     = rxflitv & ~(evt.lcrdret | evt.push);
        evt.pop     = ~fifo_empty & out_ready;
        // Credits freed this cycle may be re-granted immediately
        evt.issue   = rx_enable & ((avail_q != '0) | evt.lcrdret | evt.pop);

        avail_d = CW'(CW1'(avail_q) + CW1'(evt.lcrdret) + CW1'(evt.pop)
                      - CW1'(evt.issue));
        outst_d = CW'(CW1'(outst_q) + CW1'(evt.issue)
                      - CW1'(evt.lcrdret | evt.push));

        rxlcrdv_d    = evt.issue;
        prot_err_d   = prot_err_q | evt.err;
        idle_d       = ~rx_enable & ~has_outst & fifo_empty;
        rxflitpend_d = rxflitpend;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avail_q      <= CW'(LCRD_NUM);
            outst_q      <= '0;
            rxlcrdv_q    <= 1'b0;
            prot_err_q   <= 1'b0;
            idle_q       <= 1'b1;
            rxflitpend_q <= 1'b0;
        end else begin
            avail_q      <= avail_d;
            outst_q      <= outst_d;
            rxlcrdv_q    <= rxlcrdv_d;
            prot_err_q   <= prot_err_d;
            idle_q       <= idle_d;
            rxflitpend_q <= rxflitpend_d;
        end
    end

    // Flit buffer; sized to never overflow when the transmitter obeys credits
    hni_sync_fifo #(
        .WIDTH (FLIT_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (evt.push),
        .wdata (rxflit),
        .pop   (evt.pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rxlcrdv   = rxlcrdv_q;
    assign out_valid = ~fifo_empty;
    assign out_flit  = fifo_empty ? '0 : fifo_rdata;
    assign rx_active = rxflitpend_q | ~fifo_empty;
    // Masked by rx_enable so idle never reads 1 while the link is enabled,
    // including straight out of reset
    assign idle      = idle_q & ~rx_enable;
    assign prot_err  = prot_err_q;

endmodule

// File: doc/hni_rx_lcrd_chan.md
Name: hni_rx_lcrd_chan

Overview:
Parametrised CHI RX link-layer channel receiver for the HNI: the generalised successor of the fixed DAT-channel credit block. It issues L-credits from a configurable pool, buffers received flits in a local FIFO, and returns credits to the pool only when the downstream consumer drains a flit. It absorbs LCrdReturn flits and supports link deactivation with a credit-drain idle indication. One instance is used per RX channel (REQ/DAT/RSP) between the link interface and the HNI internal queues.

Parameters:
FLIT_WIDTH, 392, flit width in bits (set per channel from the chie_defines.v widths)
LCRD_NUM, 4, L-credits granted to the transmitter; legal range 1..15
BUF_DEPTH, 4, FIFO entries; must be >= LCRD_NUM
OPC_LSB, 12, LSB of the opcode field inside the flit
OPC_WIDTH, 4, opcode field width
LCRDRET_OPC, 0, opcode value identifying an LCrdReturn flit

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active low
rx_enable  input  1  1 = link RUN (issue credits); 0 = deactivate (stop issuing)
rxflitpend  input  1  early flit-pending hint from the link
rxflitv  input  1  flit valid
rxflit  input  FLIT_WIDTH  flit payload
rxlcrdv  output  1  L-credit grant to the transmitter, registered
out_valid  output  1  FIFO head valid
out_flit  output  FLIT_WIDTH  FIFO head flit; zero when out_valid=0
out_ready  input  1  consumer accepts the head flit
rx_active  output  1  clock-gating hint: registered rxflitpend OR FIFO non-empty
idle  output  1  no credits outstanding, FIFO empty, rx_enable=0
prot_err  output  1  sticky: flit received with zero outstanding credits

Behaviour:
- Counter width CW = $clog2(LCRD_NUM+1). Counters: avail (credits not yet issued), outst (issued, flit not yet received).
- Invariant after every clock edge: avail + outst + fifo_count_of_non_LCrdReturn_flits == LCRD_NUM. The bench checks this every cycle.
- Reset values: avail=LCRD_NUM, outst=0, FIFO empty. Outputs: rxlcrdv=0, out_valid=0, out_flit=0, rx_active=0, idle=1 (only if rx_enable=0), prot_err=0.
- Credit issue: issue_s0 = rx_enable & (avail!=0 or a credit is freed this cycle). Effect: rxlcrdv<=issue_s0; avail -1; outst +1. At most one grant per cycle. The first rxlcrdv appears one cycle after rx_enable is sampled high.
- Flit receive, with rxflitv=1 and outst!=0: outst -1.
  - Opcode==LCRDRET_OPC: the flit is not buffered; its credit goes straight back to avail (+1).
  - Otherwise: the flit is pushed into the FIFO and appears on out_valid/out_flit the next cycle.
- Drain: out_valid & out_ready pops the head; avail +1 in the same edge.
- Simultaneous events: issue, LCrdReturn receipt and pop may all occur in one cycle. Counters take the net sum, e.g. avail_nxt = avail - issue + lcrdret + pop. A credit freed in cycle N can be re-issued in cycle N (bypass). No double count and no underflow.
- Error: rxflitv with outst==0 drops the flit; no counter changes; prot_err is set and held until reset.
- FIFO full cannot occur legally (BUF_DEPTH >= LCRD_NUM). A push when full is treated as prot_err and the flit is dropped.
- Deactivation: rx_enable=0 stops new grants immediately, including one already computed that cycle. Outstanding credits return via LCrdReturn or data flits.
- idle = ~rx_enable & outst==0 & FIFO empty. Registered; rises one cycle after the condition.
- Re-enabling resumes issuing from the current avail.
- Reset mid-operation: all state, including FIFO contents and credits in flight, is discarded asynchronously. The link layer is responsible for resynchronising the transmitter.
- rx_active = rxflitpend_q | ~fifo_empty, registered on rxflitpend. It is a hint only and does not gate capture.

Decomposition:
- hni_defines.v: opcode field macros and per-channel LCrdReturn opcode constants.
- hni_param.v: default LCRD_NUM and BUF_DEPTH per channel.
- Sub-module hni_sync_fifo (params WIDTH, DEPTH): push/pop, full/empty, count, wrap-around pointers, async active-low reset. It is reused by other HNI queues.
- Credit counters and the issue logic stay in the top module.

Test Plan:
- Reset release with rx_enable=1, LCRD_NUM=4, no flits -> rxlcrdv high for exactly 4 consecutive cycles starting cycle 1; avail=0, outst=4; then rxlcrdv stays 0.
- 4 data flits with out_ready=0 -> out_valid=1 from the cycle after the first flit, FIFO count=4, no new rxlcrdv. Then pop one per cycle -> each pop produces rxlcrdv the same edge, 4 grants total, flits in order.
- LCrdReturn flit (opcode 0) after full grant -> not visible on out_valid; rxlcrdv re-asserted next cycle.
- Same cycle pop + LCrdReturn with rx_enable=1, avail=0 -> avail_nxt = 1 (2 freed, 1 issued); rxlcrdv=1; invariant holds.
- rx_enable 1->0 with outst=3, then 3 LCrdReturn flits -> no rxlcrdv after the drop; idle=1 one cycle after the third flit; re-enable -> 4 grants.
- rxflitv with outst=0 -> flit dropped, out_valid stays 0, prot_err=1 and held until rst_n pulse.
